// File: rtl/rcon_gen.sv
`default_nettype none
// ============================================================================
// Module   : rcon_gen
// Brief    : Sequential AES round-constant generator (GF(2^WIDTH) doubling),
//            valid/ready streaming. Macro RCON_REVERSE_EN adds reverse order.
// Revision : 1.0 - initial release
// ============================================================================
module rcon_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1B,
    parameter int               CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             clear,
    input  logic [1:0]       key_mode,
    input  logic             rev,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rcon_out,
    output logic             rcon_valid,
    output logic [CNT_W-1:0] round_num,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             mode_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
`ifdef RCON_REVERSE_EN
    localparam logic [1:0] c_st_prime = 2'd1;
    localparam logic [WIDTH-1:0] c_msb = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_two = CNT_W'(2);
`endif
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [CNT_W-1:0] c_n128 = CNT_W'(10);
    localparam logic [CNT_W-1:0] c_n192 = CNT_W'(8);
    localparam logic [CNT_W-1:0] c_n256 = CNT_W'(7);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] f_xtime(input logic [WIDTH-1:0] r);
        return {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0);
    endfunction

`ifdef RCON_REVERSE_EN
    // Inverse doubling: an odd value must have been reduced, so undo POLY and restore the MSB.
    function automatic logic [WIDTH-1:0] f_inv_xtime(input logic [WIDTH-1:0] r);
        return r[0] ? (((r ^ POLY) >> 1) | c_msb) : (r >> 1);
    endfunction
`endif

    logic [1:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rcon, w_rcon_nxt, w_step;
    logic [CNT_W-1:0] r_round, w_round_nxt, r_n, w_n_nxt, w_n_sel, w_round_step;
    logic             r_mode_err, w_mode_err_nxt;
    logic             w_last;
`ifdef RCON_REVERSE_EN
    logic             r_rev, w_rev_nxt;
`else
    logic             w_unused_rev;
    assign w_unused_rev = rev;
`endif

    always_comb begin
        w_n_sel = c_n128;
        case (key_mode)
            2'b00:   w_n_sel = c_n128;
            2'b01:   w_n_sel = c_n192;
            2'b10:   w_n_sel = c_n256;
            default: w_n_sel = c_n128;
        endcase
    end

`ifdef RCON_REVERSE_EN
    assign w_last       = r_rev ? (r_round == '0) : (r_round == r_n - c_one);
    assign w_step       = r_rev ? f_inv_xtime(r_rcon) : f_xtime(r_rcon);
    assign w_round_step = r_rev ? (r_round - c_one) : (r_round + c_one);
`else
    assign w_last       = (r_round == r_n - c_one);
    assign w_step       = f_xtime(r_rcon);
    assign w_round_step = r_round + c_one;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_rcon_nxt     = r_rcon;
        w_round_nxt    = r_round;
        w_n_nxt        = r_n;
        w_mode_err_nxt = 1'b0;
`ifdef RCON_REVERSE_EN
        w_rev_nxt      = r_rev;
`endif
        if (clear) begin
            w_state_nxt = c_st_idle;
            w_rcon_nxt  = '0;
            w_round_nxt = '0;
`ifdef RCON_REVERSE_EN
            w_rev_nxt   = 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_n_nxt        = w_n_sel;
                        w_mode_err_nxt = (key_mode == 2'b11);
                        w_rcon_nxt     = WIDTH'(1);
                        w_round_nxt    = '0;
                        w_state_nxt    = c_st_run;
`ifdef RCON_REVERSE_EN
                        w_rev_nxt      = rev;
                        if (rev) w_state_nxt = c_st_prime;
`endif
                    end
                end
`ifdef RCON_REVERSE_EN
                // Walk forward to the final constant; round counts the doublings applied.
                c_st_prime: begin
                    w_rcon_nxt  = f_xtime(r_rcon);
                    w_round_nxt = r_round + c_one;
                    if (r_round == r_n - c_two) w_state_nxt = c_st_run;
                end
`endif
                c_st_run: begin
                    if (rd_ready) begin
                        if (w_last) begin
                            w_state_nxt = c_st_done;
                        end else begin
                            w_rcon_nxt  = w_step;
                            w_round_nxt = w_round_step;
                        end
                    end
                end
                c_st_done: begin
                    w_state_nxt = c_st_idle;
                    w_round_nxt = '0;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= c_st_idle;
            r_rcon     <= '0;
            r_round    <= '0;
            r_n        <= c_n128;
            r_mode_err <= 1'b0;
`ifdef RCON_REVERSE_EN
            r_rev      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rcon     <= w_rcon_nxt;
            r_round    <= w_round_nxt;
            r_n        <= w_n_nxt;
            r_mode_err <= w_mode_err_nxt;
`ifdef RCON_REVERSE_EN
            r_rev      <= w_rev_nxt;
`endif
        end
    end

    assign rcon_valid = (r_state == c_st_run);
    assign rcon_out   = rcon_valid ? r_rcon : '0;
    assign round_num  = r_round;
    assign last       = rcon_valid & w_last;
    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign mode_err   = r_mode_err;

endmodule
`default_nettype wire
